// File: rtl/conv1_wm_loader.sv
// ---------------------------------------------------------------------------
// conv1_wm_loader
//
// Fill stage for the conv1 weight RAM. A narrow valid/ready weight stream is
// packed beat by beat into full RAM words (beat 0 in the LSBs), and each
// completed word is written to the RAM write port at sequential addresses
// starting from 0. A load ends on s_last or after DEPTH words. A trailing
// partial word is written with its unfilled lanes zero. done pulses one cycle
// after the final write, so port B readers see the complete image.
//
// Ports:
//   clk          - single clock (also clocks the RAM)
//   rst_n        - asynchronous active-low reset, aborts any load
//   start        - one-cycle pulse, begins a load when idle
//   s_valid      - stream beat valid
//   s_data       - stream beat, IN_WIDTH bits
//   s_last       - final beat of the load, qualified by s_valid
//   s_ready      - stream ready, high only while loading
//   wea          - RAM write enable, one cycle per word
//   addra        - RAM write address
//   dina         - RAM write data, OUT_WIDTH bits
//   busy         - high from the cycle after start through the done cycle
//   done         - one-cycle pulse when the load is complete
//   words_loaded - words written in the last/current load
// ---------------------------------------------------------------------------
module conv1_wm_loader #(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 512,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 242
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [OUT_WIDTH-1:0]  dina,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int BEATS  = OUT_WIDTH / IN_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_next;

  logic [BEAT_W-1:0]     beat_cnt;
  logic [OUT_WIDTH-1:0]  pack;
  logic [OUT_WIDTH-1:0]  pack_merged;
  logic [ADDR_WIDTH-1:0] word_ptr;
  logic accept, word_full, commit, end_load;

  // The word pointer is simply the low bits of the words-written count.
  assign word_ptr = words_loaded[ADDR_WIDTH-1:0];

  // Status outputs are pure decodes of the state, so reset forces them low
  // without waiting for a clock.
  assign s_ready = (state == LOAD);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // Beat acceptance and the pack register with the incoming beat merged in.
  // A word is committed when its last lane arrives or when s_last closes a
  // partial word; committing a partial word here puts its write in the
  // FLUSH cycle, one cycle ahead of done.
  always_comb begin
    accept      = s_valid && (state == LOAD);
    word_full   = (beat_cnt == LAST_BEAT);
    commit      = accept && (word_full || s_last);
    end_load    = accept && (s_last || (word_full && (word_ptr == LAST_WORD)));
    pack_merged = pack;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt == BEAT_W'(k)) begin
        pack_merged[k*IN_WIDTH +: IN_WIDTH] = s_data;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. FLUSH and DONE each last exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (end_load) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Packing datapath and RAM write port. The output registers are separate
  // from the pack register so the next word can start filling in the same
  // cycle a finished word is being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt     <= '0;
      pack         <= '0;
      words_loaded <= '0;
      wea          <= 1'b0;
      addra        <= '0;
      dina         <= '0;
    end else begin
      wea <= 1'b0;
      if ((state == IDLE) && start) begin
        beat_cnt     <= '0;
        pack         <= '0;
        words_loaded <= '0;
      end else if (accept) begin
        if (commit) begin
          wea          <= 1'b1;
          addra        <= word_ptr;
          dina         <= pack_merged;
          words_loaded <= words_loaded + 1'b1;
          beat_cnt     <= '0;
          pack         <= '0;
        end else begin
          pack     <= pack_merged;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv1_wm_loader.sv
// ---------------------------------------------------------------------------
// tb_conv1_wm_loader
//
// Directed bench for conv1_wm_loader. A RAM model captures every write and
// offers a port B read with two-cycle latency. Inputs are driven and outputs
// sampled just after the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_conv1_wm_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         s_valid = 1'b0;
  logic [63:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic         wea;
  logic [7:0]   addra;
  logic [511:0] dina;
  logic         busy;
  logic         done;
  logic [8:0]   words_loaded;

  conv1_wm_loader #(
    .IN_WIDTH  (64),
    .OUT_WIDTH (512),
    .ADDR_WIDTH(8),
    .DEPTH     (242)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .busy        (busy),
    .done        (done),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Cycle counter, advanced on every active edge.
  int cycle = 0;
  always @(posedge clk) cycle++;

  // RAM model and write/done monitor, sampled on the falling edge.
  logic [511:0] ram [0:255];
  int wr_total = 0;
  int done_total = 0;
  int last_wea_cycle = 0;
  int done_cycle = 0;
  logic [7:0] addr_log [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (wea) begin
        ram[addra] = dina;
        wr_total++;
        last_wea_cycle = cycle;
        addr_log.push_back(addra);
      end
      if (done) begin
        done_total++;
        done_cycle = cycle;
      end
    end
  end

  // Port B of the RAM model: two-cycle read latency.
  logic [7:0]   addrb = '0;
  logic [511:0] doutb_q;
  logic [511:0] doutb;
  always @(posedge clk) begin
    doutb_q <= ram[addrb];
    doutb   <= doutb_q;
  end

  // Per-load bookkeeping, snapshotted when a load starts.
  int wr_base = 0;
  int done_base = 0;
  int log_base = 0;

  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Word whose lane k holds base+k.
  function automatic logic [511:0] make_word(input longint base);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*64 +: 64] = 64'(base + k);
    return w;
  endfunction

  // Offer one beat; waited reports how many cycles it sat stalled.
  task automatic apply_stimulus(input logic [63:0] d, input logic last, input int bound,
                                output bit ok, output int waited);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    ok      = 1'b0;
    waited  = 0;
    for (int t = 0; t < bound; t++) begin
      if (s_ready) ok = 1'b1;
      step();
      if (ok) break;
      waited++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic begin_load();
    wr_base   = wr_total;
    done_base = done_total;
    log_base  = addr_log.size();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int t = 0; t < bound; t++) begin
      if (done_total > done_base) break;
      step();
    end
    check_output(tag, 512'(done_total > done_base), 512'd1);
  endtask

  task automatic check_addr_seq(input string tag, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (log_base + i >= addr_log.size()) errs++;
      else if (addr_log[log_base + i] !== 8'(i)) errs++;
    end
    check_output(tag, 512'(errs), 512'd0);
  endtask

  task automatic read_port_b(input logic [7:0] a, output logic [511:0] q);
    addrb = a;
    step();
    step();
    q = doutb;
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int waited;
    int stalls;
    int extra_ok;
    logic [511:0] exp_w;
    logic [511:0] rd;

    // ---- Reset --------------------------------------------------------
    repeat (3) step();
    check_output("rst_wea", 512'(wea), 512'd0);
    check_output("rst_addra", 512'(addra), 512'd0);
    check_output("rst_dina", dina, 512'd0);
    check_output("rst_ready", 512'(s_ready), 512'd0);
    check_output("rst_busy", 512'(busy), 512'd0);
    check_output("rst_done", 512'(done), 512'd0);
    check_output("rst_words", 512'(words_loaded), 512'd0);
    rst_n = 1'b1;
    s_valid = 1'b1;
    repeat (4) step();
    check_output("idle_no_wea", 512'(wr_total), 512'd0);
    check_output("idle_ready", 512'(s_ready), 512'd0);
    check_output("idle_busy", 512'(busy), 512'd0);
    s_valid = 1'b0;
    step();

    // ---- Full load: 1936 back-to-back beats, s_last on the last ---------
    begin_load();
    check_output("full_busy_after_start", 512'(busy), 512'd1);
    stalls = 0;
    for (int i = 0; i < 1936; i++) begin
      apply_stimulus(64'(i), (i == 1935), 20, ok, waited);
      stalls += waited;
    end
    check_output("full_ready_continuous", 512'(stalls), 512'd0);
    wait_done("full_done_seen", 20);
    check_output("full_writes", 512'(wr_total - wr_base), 512'd242);
    check_addr_seq("full_addr_seq", 242);
    check_output("full_word0", ram[0], make_word(0));
    check_output("full_word241", ram[241], make_word(1928));
    check_output("full_done_gap", 512'(done_cycle - last_wea_cycle), 512'd1);
    check_output("full_words_loaded", 512'(words_loaded), 512'd242);
    check_output("full_busy_at_done", 512'(busy), 512'd1);
    step();
    check_output("full_busy_after", 512'(busy), 512'd0);
    check_output("full_done_pulse", 512'(done), 512'd0);

    // ---- Short load: 20 beats, partial third word -----------------------
    begin_load();
    for (int i = 0; i < 20; i++) apply_stimulus(64'(i), (i == 19), 20, ok, waited);
    wait_done("short_done_seen", 20);
    exp_w = '0;
    for (int k = 0; k < 4; k++) exp_w[k*64 +: 64] = 64'(16 + k);
    check_output("short_writes", 512'(wr_total - wr_base), 512'd3);
    check_addr_seq("short_addr_seq", 3);
    check_output("short_word1", ram[1], make_word(8));
    check_output("short_word2_padded", ram[2], exp_w);
    check_output("short_words_loaded", 512'(words_loaded), 512'd3);
    check_output("short_done_gap", 512'(done_cycle - last_wea_cycle), 512'd1);
    step();

    // ---- Gaps plus an ignored mid-load start ---------------------------
    begin_load();
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) step();
      if (i == 12) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
      apply_stimulus(64'(32'hA000 + i), (i == 23), 20, ok, waited);
    end
    wait_done("gap_done_seen", 20);
    check_output("gap_writes", 512'(wr_total - wr_base), 512'd3);
    check_addr_seq("gap_addr_seq", 3);
    check_output("gap_word0", ram[0], make_word(32'hA000));
    check_output("gap_word1", ram[1], make_word(32'hA008));
    check_output("gap_word2", ram[2], make_word(32'hA010));
    check_output("gap_words_loaded", 512'(words_loaded), 512'd3);
    step();

    // ---- Overrun: no s_last, extra beats must stall ---------------------
    begin_load();
    for (int i = 0; i < 1936; i++) apply_stimulus(64'(32'h10000 + i), 1'b0, 20, ok, waited);
    check_output("over_ready_low", 512'(s_ready), 512'd0);
    extra_ok = 0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(64'hDEAD_0000 + 64'(i), 1'b0, 2, ok, waited);
      extra_ok += int'(ok);
    end
    wait_done("over_done_seen", 10);
    repeat (3) step();
    check_output("over_extra_accepted", 512'(extra_ok), 512'd0);
    check_output("over_writes", 512'(wr_total - wr_base), 512'd242);
    check_addr_seq("over_addr_seq", 242);
    check_output("over_done_once", 512'(done_total - done_base), 512'd1);
    check_output("over_word241", ram[241], make_word(32'h10000 + 1928));
    check_output("over_words_loaded", 512'(words_loaded), 512'd242);

    // ---- Reset mid-load, on a word boundary so wea is high ---------------
    begin_load();
    for (int i = 0; i < 48; i++) apply_stimulus(64'(32'h5000 + i), 1'b0, 20, ok, waited);
    check_output("midrst_wea_before", 512'(wea), 512'd1);
    rst_n = 1'b0;
    #1;
    check_output("midrst_wea_async", 512'(wea), 512'd0);
    check_output("midrst_busy", 512'(busy), 512'd0);
    check_output("midrst_words", 512'(words_loaded), 512'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    begin_load();
    for (int i = 0; i < 16; i++) apply_stimulus(64'(32'h7000 + i), (i == 15), 20, ok, waited);
    wait_done("reload_done_seen", 20);
    check_output("reload_writes", 512'(wr_total - wr_base), 512'd2);
    check_addr_seq("reload_addr_seq", 2);
    check_output("reload_words_loaded", 512'(words_loaded), 512'd2);
    read_port_b(8'd0, rd);
    check_output("reload_portb_word0", rd, make_word(32'h7000));
    read_port_b(8'd1, rd);
    check_output("reload_portb_word1", rd, make_word(32'h7008));
    read_port_b(8'd2, rd);
    check_output("reload_portb_word2_kept", rd, make_word(32'h5010));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
